calc2_multiport_core: RTL

- Parametrised successor to the calc1 datapath. NPORTS requesters each issue tagged two-cycle commands into a per-port request FIFO.
- Two shared execution units serve the FIFOs under independent round-robin arbiters: an add unit for add, sub and invalid commands, and a shift unit.
- Responses return to the originating port in order, with tag echo and per-port backpressure.
- Sits between the requester interface and the top-level output wiring. It replaces the fixed 4-port holdreg/priority/mux_out structure.

---
 rtl/calc2_multiport_core_if.sv | 25 ++
 rtl/calc2_multiport_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_multiport_core_if.sv
// Requester/response bundle for calc2_multiport_core. Every vector is MSB-first
// ([0:N-1]) and port p owns the lowest-indexed slice belonging to it.
interface calc2_multiport_core_if #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 32,
  parameter int TAGW   = 2
);
  logic [0:NPORTS*4-1]     req_cmd_in;
  logic [0:NPORTS*WIDTH-1] req_data_in;
  logic [0:NPORTS*TAGW-1]  req_tag_in;
  logic [0:NPORTS-1]       req_ready;
  logic [0:NPORTS*2-1]     out_resp;
  logic [0:NPORTS*WIDTH-1] out_data;
  logic [0:NPORTS*TAGW-1]  out_tag;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  req_ready, out_resp, out_data, out_tag
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output req_ready, out_resp, out_data, out_tag
  );
endinterface

// File: rtl/calc2_multiport_core.sv
// NPORTS requesters feed per-port command FIFOs; a shared add unit and a shared
// shift unit drain them round-robin and return results to the issuing port.
module calc2_multiport_core #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int TAGW   = 2
) (
  input  logic                  c_clk,
  input  logic                  reset,
  calc2_multiport_core_if.slave bus
);
  localparam int PW  = $clog2(NPORTS);
  localparam int PW1 = PW + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SHL = 4'b0101;
  localparam logic [3:0] CMD_SHR = 4'b0110;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef enum logic {ST_IDLE, ST_OP2} cap_state_t;

  typedef struct packed {
    logic [3:0]       cmd;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
  } entry_t;

  // Returns {found, index}: first requester at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] req,
                                          input logic [PW-1:0]     ptr);
    logic [PW:0]   pick;
    logic [PW:0]   sum;
    logic [PW-1:0] sel;
    pick = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + PW1'(i);
      if (sum >= PW1'(NPORTS)) sum = sum - PW1'(NPORTS);
      sel = sum[PW-1:0];
      if (req[sel]) pick = {1'b1, sel};
    end
    return pick;
  endfunction

  // FIFO heads as seen by the arbiters
  logic   [NPORTS-1:0] head_valid;
  logic   [NPORTS-1:0] head_is_shift;
  entry_t [NPORTS-1:0] head_entry;

  logic [NPORTS-1:0] add_gnt;
  logic [NPORTS-1:0] shf_gnt;
  logic              add_any;
  logic              shf_any;
  logic [PW-1:0]     add_sel;
  logic [PW-1:0]     shf_sel;

  logic [PW-1:0]     add_ptr_reg;
  logic [PW-1:0]     shf_ptr_reg;

  // Execution stage 1: operands captured in the grant cycle
  logic              add_vld_reg;
  logic [PW-1:0]     add_port_reg;
  entry_t            add_ent_reg;
  logic              shf_vld_reg;
  logic [PW-1:0]     shf_port_reg;
  logic [3:0]        shf_cmd_reg;
  logic [TAGW-1:0]   shf_tag_reg;
  logic [WIDTH-1:0]  shf_op1_reg;
  logic [SHW-1:0]    shf_amt_reg;

  // Execution stage 2 combinational results
  logic [1:0]        add_resp;
  logic [WIDTH-1:0]  add_data;
  logic [WIDTH:0]    add_sum;
  logic [WIDTH-1:0]  shf_data;

  always_comb begin
    {add_any, add_sel} = rr_pick(head_valid & ~head_is_shift, add_ptr_reg);
    {shf_any, shf_sel} = rr_pick(head_valid & head_is_shift, shf_ptr_reg);
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      add_ptr_reg  <= '0;
      shf_ptr_reg  <= '0;
      add_vld_reg  <= 1'b0;
      add_port_reg <= '0;
      add_ent_reg  <= '0;
      shf_vld_reg  <= 1'b0;
      shf_port_reg <= '0;
      shf_cmd_reg  <= CMD_NOP;
      shf_tag_reg  <= '0;
      shf_op1_reg  <= '0;
      shf_amt_reg  <= '0;
    end else begin
      add_vld_reg <= add_any;
      shf_vld_reg <= shf_any;
      if (add_any) begin
        add_port_reg <= add_sel;
        add_ent_reg  <= head_entry[add_sel];
        add_ptr_reg  <= (add_sel == PW'(NPORTS - 1)) ? '0 : add_sel + 1'b1;
      end
      if (shf_any) begin
        shf_port_reg <= shf_sel;
        shf_cmd_reg  <= head_entry[shf_sel].cmd;
        shf_tag_reg  <= head_entry[shf_sel].tag;
        shf_op1_reg  <= head_entry[shf_sel].op1;
        shf_amt_reg  <= head_entry[shf_sel].op2[SHW-1:0];
        shf_ptr_reg  <= (shf_sel == PW'(NPORTS - 1)) ? '0 : shf_sel + 1'b1;
      end
    end
  end

  // Add unit also answers invalid commands with an error and echoed tag
  always_comb begin
    add_resp = RESP_ERR;
    add_data = '0;
    add_sum  = {1'b0, add_ent_reg.op1} + {1'b0, add_ent_reg.op2};
    case (add_ent_reg.cmd)
      CMD_ADD: begin
        if (!add_sum[WIDTH]) begin
          add_resp = RESP_OK;
          add_data = add_sum[WIDTH-1:0];
        end
      end
      CMD_SUB: begin
        if (add_ent_reg.op1 >= add_ent_reg.op2) begin
          add_resp = RESP_OK;
          add_data = add_ent_reg.op1 - add_ent_reg.op2;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if (shf_cmd_reg == CMD_SHR) shf_data = shf_op1_reg >> shf_amt_reg;
    else                        shf_data = shf_op1_reg << shf_amt_reg;
  end

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      cap_state_t       state_reg;
      logic [3:0]       cap_cmd_reg;
      logic [TAGW-1:0]  cap_tag_reg;
      logic [WIDTH-1:0] cap_op1_reg;

      entry_t           mem_reg [DEPTH];
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;

      logic [1:0]       out_resp_reg;
      logic [WIDTH-1:0] out_data_reg;
      logic [TAGW-1:0]  out_tag_reg;

      logic [3:0]       cmd_in;
      logic [WIDTH-1:0] data_in;
      logic [TAGW-1:0]  tag_in;
      logic             ready;
      logic             push;
      logic             pop;
      logic             add_hit;
      logic             shf_hit;

      assign cmd_in  = bus.req_cmd_in[gi*4 +: 4];
      assign data_in = bus.req_data_in[gi*WIDTH +: WIDTH];
      assign tag_in  = bus.req_tag_in[gi*TAGW +: TAGW];

      assign ready = !reset && (state_reg == ST_IDLE) && (count_reg < CW'(DEPTH));
      assign push  = (state_reg == ST_OP2);
      assign pop   = add_gnt[gi] | shf_gnt[gi];

      assign head_valid[gi]    = (count_reg != '0);
      assign head_entry[gi]    = mem_reg[rd_ptr_reg];
      assign head_is_shift[gi] = (head_entry[gi].cmd == CMD_SHL) ||
                                 (head_entry[gi].cmd == CMD_SHR);

      assign add_gnt[gi] = add_any && (add_sel == PW'(gi));
      assign shf_gnt[gi] = shf_any && (shf_sel == PW'(gi));

      // Two-cycle capture: cmd/tag/op1 first, op2 on the following cycle
      always_ff @(posedge c_clk) begin
        if (reset) begin
          state_reg   <= ST_IDLE;
          cap_cmd_reg <= CMD_NOP;
          cap_tag_reg <= '0;
          cap_op1_reg <= '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (ready && (cmd_in != CMD_NOP)) begin
                cap_cmd_reg <= cmd_in;
                cap_tag_reg <= tag_in;
                cap_op1_reg <= data_in;
                state_reg   <= ST_OP2;
              end
            end
            ST_OP2:  state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
          endcase
        end
      end

      always_ff @(posedge c_clk) begin
        if (push) mem_reg[wr_ptr_reg] <= {cap_cmd_reg, cap_tag_reg, cap_op1_reg, data_in};
      end

      always_ff @(posedge c_clk) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
          if (pop)  rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
          case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: ;
          endcase
        end
      end

      // A port pops at most once per cycle, so at most one unit can hit it
      assign add_hit = add_vld_reg && (add_port_reg == PW'(gi));
      assign shf_hit = shf_vld_reg && (shf_port_reg == PW'(gi));

      always_ff @(posedge c_clk) begin
        if (reset) begin
          out_resp_reg <= RESP_NONE;
          out_data_reg <= '0;
          out_tag_reg  <= '0;
        end else if (add_hit) begin
          out_resp_reg <= add_resp;
          out_data_reg <= add_data;
          out_tag_reg  <= add_ent_reg.tag;
        end else if (shf_hit) begin
          out_resp_reg <= RESP_OK;
          out_data_reg <= shf_data;
          out_tag_reg  <= shf_tag_reg;
        end else begin
          out_resp_reg <= RESP_NONE;
          out_data_reg <= '0;
          out_tag_reg  <= '0;
        end
      end

      assign bus.req_ready[gi]                = ready;
      assign bus.out_resp[gi*2 +: 2]          = out_resp_reg;
      assign bus.out_data[gi*WIDTH +: WIDTH]  = out_data_reg;
      assign bus.out_tag[gi*TAGW +: TAGW]     = out_tag_reg;
    end
  endgenerate

endmodule
